// File: rtl/ofdm_frame_ctrl_if.sv
// Handshake and datapath-steering bundle between the OFDM frame sequencer and its surroundings.
// master drives go/bit_valid/ifft_done; slave is the sequencer.
interface ofdm_frame_ctrl_if #(
    parameter int N_SUB = 8
);
    localparam int AW = $clog2(N_SUB);

    logic          go;
    logic          bit_valid;
    logic          ifft_done;
    logic          s2p_shift;
    logic          sc_wr_en;
    logic [AW-1:0] sc_wr_addr;
    logic          map_en;
    logic [AW-1:0] map_addr;
    logic          ifft_start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          busy;
    logic          frame_err;

    modport master (
        output go, bit_valid, ifft_done,
        input  s2p_shift, sc_wr_en, sc_wr_addr, map_en, map_addr, ifft_start,
        input  rd_en, rd_addr, out_valid, busy, frame_err
    );

    modport slave (
        input  go, bit_valid, ifft_done,
        output s2p_shift, sc_wr_en, sc_wr_addr, map_en, map_addr, ifft_start,
        output rd_en, rd_addr, out_valid, busy, frame_err
    );
endinterface

// File: rtl/ofdm_frame_ctrl.sv
// OFDM frame sequencer: bit collection, mapper sweep, IFFT handshake, buffer readout to P2S.
// Define OFDM_CP_EN to prepend the CP_LEN cyclic-prefix reads to the output sequence.
//
// state      | meaning
// IDLE       | waiting for go
// COLLECT    | counting serial bits into subcarrier words
// MAP        | sweeping mapper entries 0..N_SUB-1
// IFFT_START | one-cycle IFFT kick, timeout timer loaded
// IFFT_WAIT  | waiting for ifft_done or timeout
// OUTPUT     | reading IFFT buffer toward P2S
// DONE       | one-cycle frame end, go decides next frame
module ofdm_frame_ctrl #(
    parameter int N_SUB        = 8,
    parameter int BITS_PER_SC  = 4,
    parameter int CP_LEN       = 2,
    parameter int IFFT_TIMEOUT = 64
) (
    input logic              clk_i,
    input logic              rst_ni,
    ofdm_frame_ctrl_if.slave bus
);
    localparam int AW = $clog2(N_SUB);
    localparam int CW = $clog2(N_SUB + CP_LEN) + 1;
    localparam int BW = (BITS_PER_SC > 1) ? $clog2(BITS_PER_SC) : 1;
    localparam int TW = (IFFT_TIMEOUT > 1) ? $clog2(IFFT_TIMEOUT) : 1;
`ifdef OFDM_CP_EN
    localparam int RD_TOTAL = N_SUB + CP_LEN;
`else
    localparam int RD_TOTAL = N_SUB;
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COLLECT    = 3'd1,
        MAP        = 3'd2,
        IFFT_START = 3'd3,
        IFFT_WAIT  = 3'd4,
        OUTPUT     = 3'd5,
        DONE       = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [AW-1:0] sc_cnt_q, sc_cnt_d;
    logic [CW-1:0] map_cnt_q, map_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic          sc_wr_en_q, sc_wr_en_d;
    logic [AW-1:0] sc_wr_addr_q, sc_wr_addr_d;
    logic          map_en_q, map_en_d;
    logic [AW-1:0] map_addr_q, map_addr_d;
    logic          ifft_start_q, ifft_start_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          frame_err_q, frame_err_d;

    logic word_done, frame_last, abort, timeout, overrun;

    assign word_done  = (state_q == COLLECT) && bus.bit_valid
                        && (bit_cnt_q == BW'(BITS_PER_SC - 1));
    assign frame_last = word_done && (sc_cnt_q == AW'(N_SUB - 1));
    // Dropping go together with the very last bit still completes the frame.
    assign abort      = (state_q == COLLECT) && !bus.go && !frame_last;
    assign timeout    = (state_q == IFFT_WAIT) && !bus.ifft_done && (tmr_q == '0);
    assign overrun    = bus.bit_valid && (state_q != IDLE) && (state_q != COLLECT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sc_cnt_q     <= '0;
            map_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            tmr_q        <= '0;
            sc_wr_en_q   <= 1'b0;
            sc_wr_addr_q <= '0;
            map_en_q     <= 1'b0;
            map_addr_q   <= '0;
            ifft_start_q <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sc_cnt_q     <= sc_cnt_d;
            map_cnt_q    <= map_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            tmr_q        <= tmr_d;
            sc_wr_en_q   <= sc_wr_en_d;
            sc_wr_addr_q <= sc_wr_addr_d;
            map_en_q     <= map_en_d;
            map_addr_q   <= map_addr_d;
            ifft_start_q <= ifft_start_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = '0;
        sc_cnt_d  = '0;
        map_cnt_d = '0;
        rd_cnt_d  = '0;
        tmr_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.go) state_d = COLLECT;
            end
            COLLECT: begin
                bit_cnt_d = bit_cnt_q;
                sc_cnt_d  = sc_cnt_q;
                if (abort) begin
                    state_d = IDLE;
                end else if (word_done) begin
                    bit_cnt_d = '0;
                    sc_cnt_d  = sc_cnt_q + AW'(1);
                    if (frame_last) state_d = MAP;
                end else if (bus.bit_valid) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            MAP: begin
                map_cnt_d = map_cnt_q + CW'(1);
                if (map_cnt_q == CW'(N_SUB - 1)) begin
                    state_d   = IFFT_START;
                    map_cnt_d = '0;
                    tmr_d     = TW'(IFFT_TIMEOUT - 1);
                end
            end
            IFFT_START: begin
                state_d = IFFT_WAIT;
                tmr_d   = tmr_q - TW'(1);
            end
            IFFT_WAIT: begin
                tmr_d = tmr_q - TW'(1);
                if (bus.ifft_done)  state_d = OUTPUT;
                else if (timeout)   state_d = IDLE;
            end
            OUTPUT: begin
                rd_cnt_d = rd_cnt_q + CW'(1);
                if (rd_cnt_q == CW'(RD_TOTAL - 1)) begin
                    state_d  = DONE;
                    rd_cnt_d = '0;
                end
            end
            DONE: begin
                state_d = bus.go ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        bus.s2p_shift = (state_q == COLLECT) && bus.bit_valid;
        sc_wr_en_d    = word_done && !abort;
        sc_wr_addr_d  = sc_wr_en_d ? sc_cnt_q : '0;
        map_en_d      = (state_d == MAP);
        map_addr_d    = map_en_d ? map_cnt_d[AW-1:0] : '0;
        ifft_start_d  = (state_d == IFFT_START);
        rd_en_d       = (state_d == OUTPUT);
`ifdef OFDM_CP_EN
        rd_addr_d     = rd_en_d ? (rd_cnt_d[AW-1:0] + AW'(N_SUB - CP_LEN)) : '0;
`else
        rd_addr_d     = rd_en_d ? rd_cnt_d[AW-1:0] : '0;
`endif
        out_valid_d   = rd_en_q;
        busy_d        = (state_d != IDLE);
        frame_err_d   = abort || timeout || overrun;
    end

    assign bus.sc_wr_en   = sc_wr_en_q;
    assign bus.sc_wr_addr = sc_wr_addr_q;
    assign bus.map_en     = map_en_q;
    assign bus.map_addr   = map_addr_q;
    assign bus.ifft_start = ifft_start_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: doc/ofdm_frame_ctrl.md
Name: ofdm_frame_ctrl

Overview:
Frame sequencer for the OFDM baseband modulator datapath. It counts serial input bits into subcarrier words and steers the S2P register and subcarrier buffer. It then sequences the mapper, starts the IFFT and waits for it. Finally it drives buffer reads (cyclic prefix, then body) toward the P2S stage and generates the top-level go/busy/outValid handshake.

Parameters:
N_SUB, 8, subcarriers per OFDM symbol (power of 2, min 4)
BITS_PER_SC, 4, serial bits per subcarrier word (16-QAM)
CP_LEN, 2, cyclic prefix length in samples (1..N_SUB-1)
IFFT_TIMEOUT, 64, max cycles to wait for ifft_done

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
go  in  1  level enable; frame runs while high
bitValid  in  1  one-cycle strobe: signalIn bit valid this cycle
ifft_done  in  1  one-cycle pulse from IFFT core
s2p_shift  out  1  shift enable for external S2P register
sc_wr_en  out  1  write assembled word to subcarrier buffer
sc_wr_addr  out  $clog2(N_SUB)  subcarrier index written
map_en  out  1  mapper enable, one entry per cycle
map_addr  out  $clog2(N_SUB)  mapper entry index
ifft_start  out  1  one-cycle IFFT start pulse
rd_en  out  1  IFFT-output buffer read enable
rd_addr  out  $clog2(N_SUB)  IFFT-output buffer read address
outValid  out  1  sample valid at P2S input
busy  out  1  frame in progress
frame_err  out  1  one-cycle error pulse

Behaviour:
- Reset (rst=0 at a rising edge): state IDLE. All counters 0. All outputs 0. Reset takes priority over all other inputs. Reset mid-frame discards the frame with no frame_err.
- Latency conventions: s2p_shift is combinational (= bitValid in COLLECT). All other outputs are registered.
- States: IDLE, COLLECT, MAP, IFFT_START, IFFT_WAIT, OUTPUT, DONE.
- IDLE:
  - go=1 → COLLECT.
  - bitValid is ignored.
- COLLECT:
  - Each bitValid increments bit_cnt.
  - When bit_cnt reaches BITS_PER_SC-1 on a bitValid: next cycle sc_wr_en=1 with sc_wr_addr=sc_cnt, then sc_cnt increments and bit_cnt wraps to 0.
  - After word N_SUB-1 is written → MAP.
  - go=0 while not on the final bit: frame_err pulse, → IDLE.
  - go falling in the same cycle as the final bit: frame completes normally.
- MAP: map_en=1 for N_SUB consecutive cycles, map_addr 0..N_SUB-1, then → IFFT_START.
- IFFT_START: ifft_start=1 for exactly one cycle, → IFFT_WAIT. The wait counter is cleared.
- IFFT_WAIT:
  - ifft_done=1 → OUTPUT.
  - If the wait counter reaches IFFT_TIMEOUT first: frame_err pulse, → IDLE.
  - ifft_done outside IFFT_WAIT is ignored.
- OUTPUT:
  - rd_en=1 every cycle, one address per cycle.
  - Address sequence: CP addresses N_SUB-CP_LEN..N_SUB-1, then 0..N_SUB-1. Total N_SUB+CP_LEN reads.
  - outValid = rd_en delayed one cycle (1-cycle buffer read latency), so the last outValid falls in DONE.
- DONE: one cycle. go=1 → COLLECT (back-to-back frames, counters cleared). go=0 → IDLE.
- busy=1 in every state except IDLE, registered. It goes high the cycle after go is sampled and low the cycle after DONE exits to IDLE.
- Overrun: bitValid in MAP, IFFT_START, IFFT_WAIT, OUTPUT or DONE is dropped. It causes a frame_err pulse; state is unaffected.
- Address arithmetic is modulo N_SUB. Counters are sized $clog2(N_SUB+CP_LEN)+1 so they do not wrap mid-sequence.

Optional Feature:
Macro OFDM_CP_EN.
- Defined: OUTPUT issues the CP_LEN prefix reads followed by N_SUB body reads (N_SUB+CP_LEN total).
- Undefined: the prefix logic is not compiled and OUTPUT issues only N_SUB reads, addresses 0..N_SUB-1. CP_LEN is ignored. All other timing is unchanged.

Test Plan:
- Nominal frame (defaults, OFDM_CP_EN): go=1, then 32 bitValid strobes with gaps; ifft_done 20 cycles after ifft_start.
  → sc_wr_en ×8 at addrs 0..7.
  → map_en 8 cycles, then a single ifft_start.
  → rd_addr 6,7,0,1,...,7 and 10 outValid cycles.
  → busy falls after DONE with go=0; frame_err never asserted.
- Abort: go dropped after 13 bits.
  → frame_err one-cycle pulse, IDLE next cycle, busy=0, no sc_wr_en for word 3.
- IFFT timeout: ifft_done never asserted.
  → frame_err exactly 64 cycles after ifft_start, → IDLE, no rd_en.
- Back-to-back: go held high across two 32-bit frames.
  → DONE → COLLECT directly, busy stays 1, second frame reads 6,7,0..7 again.
- Reset mid-OUTPUT: rst=0 on the 4th read.
  → all outputs 0 the next cycle, state IDLE, no frame_err.
  → After rst=1 and go=1, a new nominal frame completes.
- Macro off: nominal frame.
  → rd_addr 0..7 only, 8 outValid cycles.
